pc_fetch_unit: RTL and testbench

- Parametrised next-generation fetch-stage PC generator for the 5-stage RISC-V pipeline.
- Holds the fetch PC and selects the next PC by priority: trap, EX-stage redirect, stall, BTB prediction, sequential.
- Contains a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, updated from EX, so taken branches can be predicted in fetch.

---
 rtl/pc_fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC generator with a direct-mapped BTB (2-bit saturating counters).
// Next-PC priority: trap > EX redirect > stall > BTB prediction > PC+4.
// Optional build macro PC_FETCH_MISALIGN_CHK_EN adds misalign_f and keeps
// misaligned targets out of the BTB.

// One BTB entry: holds valid/tag/target/counter and applies its own update.
module pc_fetch_btb_entry #(
  parameter int XLEN = 32,
  parameter int TAGW = 26
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel_i,
  input  logic [TAGW-1:0] tag_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            taken_i,
  output logic            valid_o,
  output logic [TAGW-1:0] tag_o,
  output logic [XLEN-1:0] target_o,
  output logic [1:0]      ctr_o
);
  logic            valid_q, valid_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [1:0]      ctr_q, ctr_d;
  logic            hit;

  assign hit = valid_q && (tag_q == tag_i);

  // Entry update: train on hit, allocate only on a taken miss.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (sel_i) begin
      if (hit) begin
        if (taken_i) begin
          target_d = target_i;
          if (ctr_q != 2'b11) ctr_d = ctr_q + 2'b01;
        end else if (ctr_q != 2'b00) begin
          ctr_d = ctr_q - 2'b01;
        end
      end else if (taken_i) begin
        valid_d  = 1'b1;
        tag_d    = tag_i;
        target_d = target_i;
        ctr_d    = 2'b10;
      end
    end
  end

  // Entry state register; reset empties the entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= 2'b00;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

  assign valid_o  = valid_q;
  assign tag_o    = tag_q;
  assign target_o = target_q;
  assign ctr_o    = ctr_q;
endmodule

module pc_fetch_unit #(
  parameter int          XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int          BTB_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_f,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            redirect_e,
  input  logic [XLEN-1:0] redirect_pc_e,
  input  logic            btb_upd_en,
  input  logic [XLEN-1:0] btb_upd_pc,
  input  logic [XLEN-1:0] btb_upd_target,
  input  logic            btb_upd_taken,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] pc_plus4_f,
  output logic            pred_taken_f,
`ifdef PC_FETCH_MISALIGN_CHK_EN
  output logic            misalign_f,
`endif
  output logic [XLEN-1:0] pred_target_f
);
  localparam int IDXW = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;

  logic [XLEN-1:0] pc_q, pc_d;

  logic [BTB_ENTRIES-1:0]           ent_vld;
  logic [BTB_ENTRIES-1:0][TAGW-1:0] ent_tag;
  logic [BTB_ENTRIES-1:0][XLEN-1:0] ent_tgt;
  logic [BTB_ENTRIES-1:0][1:0]      ent_ctr;

  logic [IDXW-1:0] lk_idx, up_idx;
  logic [TAGW-1:0] lk_tag, up_tag;
  logic            lk_hit, upd_taken;
  logic            unused_upd_lsb;

  assign lk_idx = pc_q[IDXW+1:2];
  assign lk_tag = pc_q[XLEN-1:IDXW+2];
  assign up_idx = btb_upd_pc[IDXW+1:2];
  assign up_tag = btb_upd_pc[XLEN-1:IDXW+2];
  assign unused_upd_lsb = ^btb_upd_pc[1:0];

`ifdef PC_FETCH_MISALIGN_CHK_EN
  // A misaligned target trains like a not-taken outcome so it never allocates.
  assign upd_taken  = btb_upd_taken && (btb_upd_target[1:0] == 2'b00);
  assign misalign_f = (pc_q[1:0] != 2'b00);
`else
  assign upd_taken  = btb_upd_taken;
`endif

  for (genvar i = 0; i < BTB_ENTRIES; i++) begin : g_btb
    pc_fetch_btb_entry #(.XLEN(XLEN), .TAGW(TAGW)) u_ent (
      .clk      (clk),
      .rst      (rst),
      .sel_i    (btb_upd_en && (up_idx == IDXW'(i))),
      .tag_i    (up_tag),
      .target_i (btb_upd_target),
      .taken_i  (upd_taken),
      .valid_o  (ent_vld[i]),
      .tag_o    (ent_tag[i]),
      .target_o (ent_tgt[i]),
      .ctr_o    (ent_ctr[i])
    );
  end

  // Lookup reads the registered entries, so a same-cycle update is seen next cycle.
  assign lk_hit        = ent_vld[lk_idx] && (ent_tag[lk_idx] == lk_tag);
  assign pred_taken_f  = lk_hit && ent_ctr[lk_idx][1];
  assign pred_target_f = pred_taken_f ? ent_tgt[lk_idx] : '0;
  assign pc_plus4_f    = pc_q + XLEN'(4);
  assign pc_f          = pc_q;

  // Next-PC select in fixed priority order.
  always_comb begin
    pc_d = pc_plus4_f;
    if (trap_valid)        pc_d = trap_vec;
    else if (redirect_e)   pc_d = redirect_pc_e;
    else if (stall_f)      pc_d = pc_q;
    else if (pred_taken_f) pc_d = pred_target_f;
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_VECTOR;
    else      pc_q <= pc_d;
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit (default parameters).
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f, trap_valid, redirect_e, btb_upd_en, btb_upd_taken;
  logic [31:0] trap_vec, redirect_pc_e, btb_upd_pc, btb_upd_target;
  logic [31:0] pc_f, pc_plus4_f, pred_target_f;
  logic        pred_taken_f;
`ifdef PC_FETCH_MISALIGN_CHK_EN
  logic        misalign_f;
`endif
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .trap_valid(trap_valid),
    .trap_vec(trap_vec), .redirect_e(redirect_e), .redirect_pc_e(redirect_pc_e),
    .btb_upd_en(btb_upd_en), .btb_upd_pc(btb_upd_pc),
    .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken),
    .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .pred_taken_f(pred_taken_f),
`ifdef PC_FETCH_MISALIGN_CHK_EN
    .misalign_f(misalign_f),
`endif
    .pred_target_f(pred_target_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic upd(input logic en, input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    btb_upd_en = en; btb_upd_pc = pc; btb_upd_target = tgt; btb_upd_taken = tk;
  endtask

  task automatic redir_to(input logic [31:0] pc);
    redirect_e = 1'b1; redirect_pc_e = pc;
    step();
    redirect_e = 1'b0;
  endtask

  initial begin
    rst = 1'b0; stall_f = 0; trap_valid = 0; trap_vec = 0;
    redirect_e = 0; redirect_pc_e = 0;
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("rst_pc", pc_f, 32'h0);
    chk("rst_pc4", pc_plus4_f, 32'h4);
    chk("rst_pred", {31'b0, pred_taken_f}, 32'h0);
    chk("rst_tgt", pred_target_f, 32'h0);

    rst = 1'b1;
    step(); chk("seq1", pc_f, 32'h4);
    step(); chk("seq2", pc_f, 32'h8);
    step(); chk("seq3", pc_f, 32'hC);

    redir_to(32'h20); chk("redir20", pc_f, 32'h20);
    stall_f = 1; redirect_e = 1; redirect_pc_e = 32'h100;
    step(); chk("redir_over_stall", pc_f, 32'h100);
    trap_valid = 1; trap_vec = 32'h80;
    step(); chk("trap_over_redir", pc_f, 32'h80);
    trap_valid = 0; redirect_e = 0;
    step(); chk("stall_hold", pc_f, 32'h80);
    stall_f = 0;

    // Allocate 0x40 -> 0x200 and follow the prediction.
    upd(1'b1, 32'h40, 32'h200, 1'b1);
    step(); chk("seq84", pc_f, 32'h84);
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    redir_to(32'h40);
    chk("pred40", {31'b0, pred_taken_f}, 32'h1);
    chk("pred40_tgt", pred_target_f, 32'h200);
    step(); chk("follow_pred", pc_f, 32'h200);
    chk("miss200", {31'b0, pred_taken_f}, 32'h0);

    // Two not-taken updates: ctr 10 -> 01 -> 00.
    upd(1'b1, 32'h40, 32'h0, 1'b0);
    step(); step();
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    redir_to(32'h40);
    chk("nt40_pred", {31'b0, pred_taken_f}, 32'h0);
    chk("nt40_tgt", pred_target_f, 32'h0);

    // Same index, different tag replaces the entry.
    upd(1'b1, 32'h80, 32'h300, 1'b1);
    step();
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    redir_to(32'h40);
    chk("repl_40_miss", {31'b0, pred_taken_f}, 32'h0);
    redir_to(32'h80);
    chk("repl_80_hit", {31'b0, pred_taken_f}, 32'h1);
    chk("repl_80_tgt", pred_target_f, 32'h300);

    // Same-cycle update and lookup, with stall holding pc_f at 0x80.
    stall_f = 1;
    upd(1'b1, 32'h80, 32'h400, 1'b1);
    #1 chk("same_cyc_old", pred_target_f, 32'h300);
    step();
    chk("same_cyc_pc", pc_f, 32'h80);
    chk("same_cyc_new", pred_target_f, 32'h400);
    stall_f = 0;
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    step(); chk("follow_400", pc_f, 32'h400);

    // Wrap-around.
    redir_to(32'hFFFF_FFFC);
    chk("wrap_pc", pc_f, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_f, 32'h0);
    step(); chk("wrap_next", pc_f, 32'h0);
    step(); chk("seq_after_wrap", pc_f, 32'h4);

    // Asynchronous reset pulse between edges with stall active.
    stall_f = 1;
    #2 rst = 1'b0;
    #1 chk("async_rst_pc", pc_f, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_hold", pc_f, 32'h0);
    stall_f = 0;
    redir_to(32'h80);
    chk("post_rst_pc", pc_f, 32'h80);
    chk("post_rst_btb_empty", {31'b0, pred_taken_f}, 32'h0);

`ifdef PC_FETCH_MISALIGN_CHK_EN
    redir_to(32'h102);
    chk("misalign", {31'b0, misalign_f}, 32'h1);
    upd(1'b1, 32'h50, 32'h206, 1'b1);
    step();
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    redir_to(32'h50);
    chk("misalign_noalloc", {31'b0, pred_taken_f}, 32'h0);
    chk("aligned_flag", {31'b0, misalign_f}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
